// File: rtl/bus8088_pkg.sv
// bus8088_pkg: shared state, request types and bus polarity constants for the 8088 initiator
package bus8088_pkg;
  localparam int BUS_ADDR_W = 20;
  localparam int BUS_DATA_W = 8;
  localparam logic ALE_ON = 1'b1;
  localparam logic STB_ON = 1'b0;
  localparam logic STB_OFF = 1'b1;
  typedef enum logic [2:0] {IDLE, T1, T2, T3, TW, T4, HLD} bus_state_e;
  typedef struct packed {
    logic write;
    logic iom;
    logic [BUS_ADDR_W-1:0] addr;
    logic [BUS_DATA_W-1:0] wdata;
  } bus_req_t;
endpackage

// File: rtl/bus8088_initiator.sv
// bus8088_initiator: 8088 minimum-mode T1-T4 bus-cycle initiator with wait timeout and HOLD/HLDA
module bus8088_initiator
  import bus8088_pkg::*;
#(
  parameter int ADDR_W = BUS_ADDR_W,
  parameter int DATA_W = BUS_DATA_W,
  parameter int IO_ADDR_W = 16,
  parameter int WAIT_LIMIT = 16
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_iom,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-9:0] A,
  output logic [DATA_W-1:0] AD_O,
  output logic              AD_OE,
  input  logic [DATA_W-1:0] AD_I,
  output logic              ALE,
  output logic              RD_N,
  output logic              WR_N,
  output logic              IOM,
  output logic              DTR,
  output logic              DEN_N,
  output logic              BUS_OE,
  input  logic              READY,
  input  logic              HOLD,
  output logic              HLDA
);
  localparam int CW = WAIT_LIMIT == 0 ? 1 : $clog2(WAIT_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(WAIT_LIMIT);
  localparam logic [ADDR_W-1:0] IO_MASK = ADDR_W'((64'd1 << IO_ADDR_W) - 64'd1);
  bus_state_e st;
  bus_req_t r;
  logic [CW-1:0] cnt;
  logic err;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] amask;
  logic accept, strobe, data_ph, sample, timeout;
  assign req_ready = (st == IDLE || st == T4) && !HOLD && RESET_N;
  assign accept = req_valid && req_ready;
  assign amask = req_iom ? IO_MASK : '1;
  assign strobe = st == T2 || st == T3 || st == TW;
  assign data_ph = strobe || st == T4;
  assign sample = st == T3 || st == TW;
  assign timeout = WAIT_LIMIT != 0 && cnt == LIM;
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      st <= IDLE;
      r <= '0;
      cnt <= '0;
      err <= 1'b0;
      rdata <= '0;
    end else begin
      case (st)
        IDLE, T4: st <= HOLD ? HLD : accept ? T1 : IDLE;
        T1: st <= T2;
        T2: st <= T3;
        T3: st <= READY ? T4 : TW;
        TW: st <= READY || timeout ? T4 : TW;
        HLD: st <= HOLD ? HLD : IDLE;
        default: st <= IDLE;
      endcase
      if (accept) begin
        r <= '{write: req_write, iom: req_iom, addr: req_addr & amask, wdata: req_wdata};
        err <= 1'b0;
      end
      // cnt counts TW states of the current cycle; it equals k while in the k-th TW
      if (st == T1)
        cnt <= '0;
      else if (sample && !READY)
        cnt <= cnt + 1'b1;
      if (st == TW && !READY && timeout)
        err <= 1'b1;
      if (sample && READY && !r.write)
        rdata <= AD_I;
    end
  always_comb begin
    ALE = st == T1 ? ALE_ON : ~ALE_ON;
    RD_N = strobe && !r.write ? STB_ON : STB_OFF;
    WR_N = strobe && r.write ? STB_ON : STB_OFF;
    DEN_N = strobe ? STB_ON : STB_OFF;
    A = r.addr[ADDR_W-1:8];
    AD_O = st == T1 ? r.addr[DATA_W-1:0] : r.write && data_ph ? r.wdata : '0;
    AD_OE = st == T1 || (r.write && data_ph);
    IOM = r.iom;
    DTR = r.write;
    BUS_OE = st != HLD;
    HLDA = st == HLD;
    resp_valid = st == T4;
    resp_err = st == T4 && err;
    resp_rdata = rdata;
  end
endmodule
